led_blink_ctrl: RTL

Command-driven controller for the 8-LED bank on the blink board. It replaces a fixed divide-by-N blinker with per-LED modes: off, on, blink, and one-shot. A single shared prescaler generates a base tick, and each LED runs its own half-period counter in base ticks. Commands arrive over a valid/ready handshake from the remote-control front end (UART decoder or host register block). The block drives the board `leds` pins directly.

---
 rtl/led_blink_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/led_blink_ctrl.sv
// rtl/led_blink_ctrl.sv - command-driven per-LED off/on/blink/one-shot controller
module led_blink_ctrl #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TICK_HZ  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_led,
  input  logic [1:0] cmd_mode,
  input  logic [3:0] cmd_period,
  output logic [7:0] leds,
  output logic [7:0] shot_done,
  output logic       tick
);

  localparam int          TICK_CYCLES = CLK_FREQ / TICK_HZ;
  localparam logic [31:0] TICK_LAST   = 32'(TICK_CYCLES - 1);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  typedef enum logic {S_IDLE, S_APPLY} state_t;

  state_t          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic [31:0]     presc_q, presc_d;
  logic            at_top_q, at_top_d;
  logic [2:0]      lat_led_q, lat_led_d;
  logic [1:0]      lat_mode_q, lat_mode_d;
  logic [3:0]      lat_period_q, lat_period_d;
  logic [7:0][1:0] mode_q, mode_d;
  logic [7:0][3:0] period_q, period_d;
  logic [7:0][3:0] cnt_q, cnt_d;
  logic [7:0]      leds_q, leds_d;
  logic [7:0]      shot_done_q, shot_done_d;

  // at_top_q marks the prescaler resting on its last count; en gates it so a
  // frozen prescaler never strobes
  assign tick      = at_top_q & en;
  assign cmd_ready = cmd_ready_q;
  assign leds      = leds_q;
  assign shot_done = shot_done_q;

  // next-state: prescaler, per-LED tick processing, then the command apply
  // (applied last so it overrides any tick effect on the targeted LED)
  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    presc_d      = presc_q;
    at_top_d     = at_top_q;
    lat_led_d    = lat_led_q;
    lat_mode_d   = lat_mode_q;
    lat_period_d = lat_period_q;
    mode_d       = mode_q;
    period_d     = period_q;
    cnt_d        = cnt_q;
    leds_d       = leds_q;
    shot_done_d  = 8'h00;

    if (en) begin
      presc_d  = (presc_q == TICK_LAST) ? 32'd0 : presc_q + 32'd1;
      at_top_d = (presc_d == TICK_LAST);
    end

    if (tick) begin
      for (int i = 0; i < 8; i++) begin
        if (mode_q[i] == MODE_BLINK) begin
          if (cnt_q[i] == period_q[i] - 4'd1) begin
            leds_d[i] = ~leds_q[i];
            cnt_d[i]  = 4'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
          end
        end else if (mode_q[i] == MODE_ONESHOT) begin
          if (cnt_q[i] == period_q[i] - 4'd1) begin
            leds_d[i]      = 1'b0;
            mode_d[i]      = MODE_OFF;
            cnt_d[i]       = 4'd0;
            shot_done_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
          end
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          lat_led_d    = cmd_led;
          lat_mode_d   = cmd_mode;
          lat_period_d = (cmd_period == 4'd0) ? 4'd1 : cmd_period;
          state_d      = S_APPLY;
          cmd_ready_d  = 1'b0;
        end
      end
      default: begin
        mode_d[lat_led_q]      = lat_mode_q;
        period_d[lat_led_q]    = lat_period_q;
        cnt_d[lat_led_q]       = 4'd0;
        leds_d[lat_led_q]      = (lat_mode_q != MODE_OFF);
        shot_done_d[lat_led_q] = 1'b0;
        state_d                = S_IDLE;
        cmd_ready_d            = 1'b1;
      end
    endcase
  end

  // all state registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b1;
      presc_q      <= 32'd0;
      at_top_q     <= 1'b0;
      lat_led_q    <= 3'd0;
      lat_mode_q   <= MODE_OFF;
      lat_period_q <= 4'd1;
      for (int i = 0; i < 8; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= 4'd1;
        cnt_q[i]    <= 4'd0;
      end
      leds_q       <= 8'h00;
      shot_done_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      presc_q      <= presc_d;
      at_top_q     <= at_top_d;
      lat_led_q    <= lat_led_d;
      lat_mode_q   <= lat_mode_d;
      lat_period_q <= lat_period_d;
      mode_q       <= mode_d;
      period_q     <= period_d;
      cnt_q        <= cnt_d;
      leds_q       <= leds_d;
      shot_done_q  <= shot_done_d;
    end
  end

endmodule
